// File: rtl/raster_tile_sched.sv
// Tile scheduler: walks a triangle's bounding box in TxT tiles in raster order,
// carrying the edge values per tile and optionally dropping tiles outside any edge.
module raster_tile_sched #(
   parameter int TILE_LOG2 = 4,
   parameter bit CULL_EN   = 1'b1
) (
   input  logic               clock_i,
   input  logic               reset_i,
   input  logic [23:0]        area_i,
   input  logic signed [16:0] dl_w0_col_i,
   input  logic signed [16:0] dl_w1_col_i,
   input  logic signed [16:0] dl_w2_col_i,
   input  logic signed [16:0] dl_w0_row_i,
   input  logic signed [16:0] dl_w1_row_i,
   input  logic signed [16:0] dl_w2_row_i,
   input  logic signed [24:0] w0_row_i,
   input  logic signed [24:0] w1_row_i,
   input  logic signed [24:0] w2_row_i,
   input  logic [11:0]        x_min_i,
   input  logic [11:0]        y_min_i,
   input  logic [11:0]        x_max_i,
   input  logic [11:0]        y_max_i,
   input  logic               valid_i,
   output logic               busy_o,
   output logic [11:0]        x_min_o,
   output logic [11:0]        y_min_o,
   output logic [11:0]        x_max_o,
   output logic [11:0]        y_max_o,
   output logic signed [24:0] w0_row_o,
   output logic signed [24:0] w1_row_o,
   output logic signed [24:0] w2_row_o,
   output logic signed [16:0] dl_w0_col_o,
   output logic signed [16:0] dl_w1_col_o,
   output logic signed [16:0] dl_w2_col_o,
   output logic signed [16:0] dl_w0_row_o,
   output logic signed [16:0] dl_w1_row_o,
   output logic signed [16:0] dl_w2_row_o,
   output logic [23:0]        area_o,
   output logic               valid_o,
   input  logic               busy_i,
   output logic [15:0]        tiles_emitted_o,
   output logic [15:0]        tiles_culled_o
);

   localparam logic [12:0] TSZ    = 13'd1 << TILE_LOG2;
   localparam logic [0:0]  S_IDLE = 1'b0;
   localparam logic [0:0]  S_WALK = 1'b1;

   logic [0:0]       state_q, state_d;
   logic             degen_q, degen_d;
   logic [11:0]      tx_q, tx_d, ty_q, ty_d;
   logic [11:0]      x_min_q, x_min_d, x_max_q, x_max_d, y_max_q, y_max_d;
   logic [2:0][24:0] w_tile_q, w_tile_d, w_rs_q, w_rs_d;
   logic [2:0][16:0] dl_col_q, dl_col_d, dl_row_q, dl_row_d;
   logic [23:0]      area_q, area_d;
   logic [15:0]      emit_q, emit_d, cull_q, cull_d;

   logic [2:0][24:0] dc_s, dr_s, span_c_s, span_r_s, c10_s, c01_s, c11_s;
   logic [2:0]       out_s;
   logic [12:0]      x_end_s, y_end_s;
   logic             last_col_s, last_row_s, walking_s, culled_s, transfer_s, advance_s;

   // Corner evaluation for the trivial-reject test and tile-end arithmetic
   always_comb begin
      for (int k = 0; k < 3; k++) begin
         dc_s[k]     = {{8{dl_col_q[k][16]}}, dl_col_q[k]};
         dr_s[k]     = {{8{dl_row_q[k][16]}}, dl_row_q[k]};
         span_c_s[k] = (dc_s[k] << TILE_LOG2) - dc_s[k];
         span_r_s[k] = (dr_s[k] << TILE_LOG2) - dr_s[k];
         c10_s[k]    = w_tile_q[k] + span_c_s[k];
         c01_s[k]    = w_tile_q[k] + span_r_s[k];
         c11_s[k]    = w_tile_q[k] + span_c_s[k] + span_r_s[k];
         out_s[k]    = w_tile_q[k][24] & c10_s[k][24] & c01_s[k][24] & c11_s[k][24];
      end
      x_end_s    = {1'b0, tx_q} + TSZ - 13'd1;
      y_end_s    = {1'b0, ty_q} + TSZ - 13'd1;
      last_col_s = x_end_s >= {1'b0, x_max_q};
      last_row_s = y_end_s >= {1'b0, y_max_q};
      walking_s  = (state_q == S_WALK) && !degen_q;
      culled_s   = CULL_EN && walking_s && (|out_s);
      valid_o    = walking_s && !culled_s;
      transfer_s = valid_o && !busy_i;
      advance_s  = culled_s || transfer_s;
   end

   // Triangle latch, cursor stepping and edge accumulation
   always_comb begin
      state_d  = state_q;
      degen_d  = degen_q;
      tx_d     = tx_q;
      ty_d     = ty_q;
      x_min_d  = x_min_q;
      x_max_d  = x_max_q;
      y_max_d  = y_max_q;
      w_tile_d = w_tile_q;
      w_rs_d   = w_rs_q;
      dl_col_d = dl_col_q;
      dl_row_d = dl_row_q;
      area_d   = area_q;
      case (state_q)
         S_IDLE: begin
            if (valid_i) begin
               state_d  = S_WALK;
               degen_d  = (x_min_i > x_max_i) || (y_min_i > y_max_i);
               tx_d     = x_min_i;
               ty_d     = y_min_i;
               x_min_d  = x_min_i;
               x_max_d  = x_max_i;
               y_max_d  = y_max_i;
               w_tile_d = {w2_row_i, w1_row_i, w0_row_i};
               w_rs_d   = {w2_row_i, w1_row_i, w0_row_i};
               dl_col_d = {dl_w2_col_i, dl_w1_col_i, dl_w0_col_i};
               dl_row_d = {dl_w2_row_i, dl_w1_row_i, dl_w0_row_i};
               area_d   = area_i;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_WALK: begin
            if (degen_q) begin
               state_d = S_IDLE;
            end else if (advance_s) begin
               if (last_col_s && last_row_s) begin
                  state_d = S_IDLE;
               end else if (last_col_s) begin
                  tx_d = x_min_q;
                  ty_d = ty_q + TSZ[11:0];
                  for (int k = 0; k < 3; k++) begin
                     w_rs_d[k]   = w_rs_q[k] + (dr_s[k] << TILE_LOG2);
                     w_tile_d[k] = w_rs_q[k] + (dr_s[k] << TILE_LOG2);
                  end
               end else begin
                  tx_d = tx_q + TSZ[11:0];
                  for (int k = 0; k < 3; k++) begin
                     w_tile_d[k] = w_tile_q[k] + (dc_s[k] << TILE_LOG2);
                  end
               end
            end else begin
               state_d = S_WALK;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Saturating statistics counters
   always_comb begin
      if (transfer_s && (emit_q != 16'hFFFF)) begin
         emit_d = emit_q + 16'd1;
      end else begin
         emit_d = emit_q;
      end
      if (culled_s && (cull_q != 16'hFFFF)) begin
         cull_d = cull_q + 16'd1;
      end else begin
         cull_d = cull_q;
      end
   end

   // State registers
   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         state_q  <= S_IDLE;
         degen_q  <= 1'b0;
         tx_q     <= 12'd0;
         ty_q     <= 12'd0;
         x_min_q  <= 12'd0;
         x_max_q  <= 12'd0;
         y_max_q  <= 12'd0;
         w_tile_q <= '0;
         w_rs_q   <= '0;
         dl_col_q <= '0;
         dl_row_q <= '0;
         area_q   <= 24'd0;
         emit_q   <= 16'd0;
         cull_q   <= 16'd0;
      end else begin
         state_q  <= state_d;
         degen_q  <= degen_d;
         tx_q     <= tx_d;
         ty_q     <= ty_d;
         x_min_q  <= x_min_d;
         x_max_q  <= x_max_d;
         y_max_q  <= y_max_d;
         w_tile_q <= w_tile_d;
         w_rs_q   <= w_rs_d;
         dl_col_q <= dl_col_d;
         dl_row_q <= dl_row_d;
         area_q   <= area_d;
         emit_q   <= emit_d;
         cull_q   <= cull_d;
      end
   end

   assign busy_o          = (state_q != S_IDLE);
   assign x_min_o         = tx_q;
   assign y_min_o         = ty_q;
   assign x_max_o         = last_col_s ? x_max_q : x_end_s[11:0];
   assign y_max_o         = last_row_s ? y_max_q : y_end_s[11:0];
   assign w0_row_o        = w_tile_q[0];
   assign w1_row_o        = w_tile_q[1];
   assign w2_row_o        = w_tile_q[2];
   assign dl_w0_col_o     = dl_col_q[0];
   assign dl_w1_col_o     = dl_col_q[1];
   assign dl_w2_col_o     = dl_col_q[2];
   assign dl_w0_row_o     = dl_row_q[0];
   assign dl_w1_row_o     = dl_row_q[1];
   assign dl_w2_row_o     = dl_row_q[2];
   assign area_o          = area_q;
   assign tiles_emitted_o = emit_q;
   assign tiles_culled_o  = cull_q;

endmodule

// File: tb/tb_raster_tile_sched.sv
// Bench: directed and random triangles against a tile-list model; a second instance
// (T=4, no cull) is cross-checked on tile counts.
module tb_raster_tile_sched;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic [23:0]        area_i = 24'd0;
   logic signed [16:0] dc0_i = 17'sd0, dc1_i = 17'sd0, dc2_i = 17'sd0;
   logic signed [16:0] dr0_i = 17'sd0, dr1_i = 17'sd0, dr2_i = 17'sd0;
   logic signed [24:0] w0_i = 25'sd0, w1_i = 25'sd0, w2_i = 25'sd0;
   logic [11:0]        xmn_i = 12'd0, ymn_i = 12'd0, xmx_i = 12'd0, ymx_i = 12'd0;
   logic               valid_i = 1'b0, busy_i = 1'b0, busy2_i = 1'b0;

   logic               busy_a, valid_a, busy_b, valid_b;
   logic [11:0]        xmn_a, ymn_a, xmx_a, ymx_a, xmn_b, ymn_b, xmx_b, ymx_b;
   logic signed [24:0] w0_a, w1_a, w2_a, w0_b, w1_b, w2_b;
   logic signed [16:0] dc0_a, dc1_a, dc2_a, dr0_a, dr1_a, dr2_a;
   logic signed [16:0] dc0_b, dc1_b, dc2_b, dr0_b, dr1_b, dr2_b;
   logic [23:0]        area_a, area_b;
   logic [15:0]        emit_a, cull_a, emit_b, cull_b;

   raster_tile_sched #(.TILE_LOG2(4), .CULL_EN(1'b1)) dut_a (
      .clock_i(clk), .reset_i(rst), .area_i(area_i),
      .dl_w0_col_i(dc0_i), .dl_w1_col_i(dc1_i), .dl_w2_col_i(dc2_i),
      .dl_w0_row_i(dr0_i), .dl_w1_row_i(dr1_i), .dl_w2_row_i(dr2_i),
      .w0_row_i(w0_i), .w1_row_i(w1_i), .w2_row_i(w2_i),
      .x_min_i(xmn_i), .y_min_i(ymn_i), .x_max_i(xmx_i), .y_max_i(ymx_i),
      .valid_i(valid_i), .busy_o(busy_a),
      .x_min_o(xmn_a), .y_min_o(ymn_a), .x_max_o(xmx_a), .y_max_o(ymx_a),
      .w0_row_o(w0_a), .w1_row_o(w1_a), .w2_row_o(w2_a),
      .dl_w0_col_o(dc0_a), .dl_w1_col_o(dc1_a), .dl_w2_col_o(dc2_a),
      .dl_w0_row_o(dr0_a), .dl_w1_row_o(dr1_a), .dl_w2_row_o(dr2_a),
      .area_o(area_a), .valid_o(valid_a), .busy_i(busy_i),
      .tiles_emitted_o(emit_a), .tiles_culled_o(cull_a)
   );

   raster_tile_sched #(.TILE_LOG2(2), .CULL_EN(1'b0)) dut_b (
      .clock_i(clk), .reset_i(rst), .area_i(area_i),
      .dl_w0_col_i(dc0_i), .dl_w1_col_i(dc1_i), .dl_w2_col_i(dc2_i),
      .dl_w0_row_i(dr0_i), .dl_w1_row_i(dr1_i), .dl_w2_row_i(dr2_i),
      .w0_row_i(w0_i), .w1_row_i(w1_i), .w2_row_i(w2_i),
      .x_min_i(xmn_i), .y_min_i(ymn_i), .x_max_i(xmx_i), .y_max_i(ymx_i),
      .valid_i(valid_i), .busy_o(busy_b),
      .x_min_o(xmn_b), .y_min_o(ymn_b), .x_max_o(xmx_b), .y_max_o(ymx_b),
      .w0_row_o(w0_b), .w1_row_o(w1_b), .w2_row_o(w2_b),
      .dl_w0_col_o(dc0_b), .dl_w1_col_o(dc1_b), .dl_w2_col_o(dc2_b),
      .dl_w0_row_o(dr0_b), .dl_w1_row_o(dr1_b), .dl_w2_row_o(dr2_b),
      .area_o(area_b), .valid_o(valid_b), .busy_i(busy2_i),
      .tiles_emitted_o(emit_b), .tiles_culled_o(cull_b)
   );

   typedef struct packed {
      logic [11:0] x0, y0, x1, y1;
      logic [24:0] w0, w1, w2;
   } tile_t;

   int    tests = 0, fails = 0;
   int    tx0, ty0, tx1, ty1, tarea;
   int    tw[3], tdc[3], tdr[3];
   tile_t exp_q[$];
   int    n_cull_exp;
   bit    first_culled;
   int    exp_emit = 0, exp_cull = 0, exp_emit2 = 0;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   function automatic bit b24(input int v);
      logic [31:0] t;
      t = v;
      return t[24];
   endfunction

   function automatic logic [255:0] vec_a();
      return 256'({xmn_a, ymn_a, xmx_a, ymx_a, w0_a, w1_a, w2_a, area_a,
                   dc0_a, dc1_a, dc2_a, dr0_a, dr1_a, dr2_a});
   endfunction

   function automatic logic [255:0] exp_vec(input tile_t t);
      return 256'({t.x0, t.y0, t.x1, t.y1, t.w0, t.w1, t.w2, 24'(tarea),
                   17'(tdc[0]), 17'(tdc[1]), 17'(tdc[2]),
                   17'(tdr[0]), 17'(tdr[1]), 17'(tdr[2])});
   endfunction

   function automatic int count_tiles(input int l);
      int t;
      t = 1 << l;
      if (tx0 > tx1 || ty0 > ty1) return 0;
      return ((tx1 - tx0) / t + 1) * ((ty1 - ty0) / t + 1);
   endfunction

   // Reference: enumerate every 16x16 tile of the box, edge value by multiplication
   task automatic build_exp();
      tile_t t;
      int    wk[3];
      bit    cl;
      bit    first = 1'b1;
      exp_q.delete();
      n_cull_exp   = 0;
      first_culled = 1'b0;
      for (int ty = ty0; ty <= ty1; ty += 16) begin
         for (int tx = tx0; tx <= tx1; tx += 16) begin
            cl = 1'b0;
            for (int k = 0; k < 3; k++) begin
               wk[k] = tw[k] + ((tx - tx0) / 16) * 16 * tdc[k] + ((ty - ty0) / 16) * 16 * tdr[k];
               if (b24(wk[k]) && b24(wk[k] + 15 * tdc[k]) && b24(wk[k] + 15 * tdr[k]) &&
                   b24(wk[k] + 15 * tdc[k] + 15 * tdr[k])) cl = 1'b1;
            end
            if (first) first_culled = cl;
            first = 1'b0;
            if (cl) begin
               n_cull_exp++;
            end else begin
               t.x0 = 12'(tx);
               t.y0 = 12'(ty);
               t.x1 = 12'((tx + 15 < tx1) ? tx + 15 : tx1);
               t.y1 = 12'((ty + 15 < ty1) ? ty + 15 : ty1);
               t.w0 = 25'(wk[0]);
               t.w1 = 25'(wk[1]);
               t.w2 = 25'(wk[2]);
               exp_q.push_back(t);
            end
         end
      end
   endtask

   task automatic set_tri(input int x0, input int y0, input int x1, input int y1,
                          input int wa, input int wb, input int wc, input int dc, input int dr);
      tx0 = x0; ty0 = y0; tx1 = x1; ty1 = y1;
      tw[0] = wa; tw[1] = wb; tw[2] = wc;
      for (int k = 0; k < 3; k++) begin
         tdc[k] = dc;
         tdr[k] = dr;
      end
      tarea = 'h12345;
   endtask

   task automatic drive_tri();
      xmn_i = 12'(tx0); ymn_i = 12'(ty0); xmx_i = 12'(tx1); ymx_i = 12'(ty1);
      w0_i = 25'(tw[0]); w1_i = 25'(tw[1]); w2_i = 25'(tw[2]);
      dc0_i = 17'(tdc[0]); dc1_i = 17'(tdc[1]); dc2_i = 17'(tdc[2]);
      dr0_i = 17'(tdr[0]); dr1_i = 17'(tdr[1]); dr2_i = 17'(tdr[2]);
      area_i = 24'(tarea);
   endtask

   task automatic scramble();
      xmn_i = 12'($urandom); ymn_i = 12'($urandom); xmx_i = 12'($urandom); ymx_i = 12'($urandom);
      w0_i = 25'($urandom); w1_i = 25'($urandom); w2_i = 25'($urandom);
      dc0_i = 17'($urandom); dc1_i = 17'($urandom); dc2_i = 17'($urandom);
      dr0_i = 17'($urandom); dr1_i = 17'($urandom); dr2_i = 17'($urandom);
      area_i = 24'($urandom);
   endtask

   task automatic run_tri(input int stall_first, input int busy_pct);
      int            cyc = 0, busy_cyc = 0, stalls = 0, ntr = 0, n_unc, n2, stall_left;
      bit            degen, held_v = 1'b0;
      logic [255:0]  held = '0;
      build_exp();
      n_unc      = exp_q.size();
      n2         = count_tiles(2);
      degen      = (tx0 > tx1) || (ty0 > ty1);
      stall_left = stall_first;
      @(negedge clk);
      drive_tri();
      valid_i = 1'b1;
      busy_i  = 1'b0;
      @(negedge clk);
      valid_i = 1'b0;
      scramble();
      while (cyc < 3000) begin
         #1;
         if (cyc == 0) begin
            chk("busy_after_accept", 256'(busy_a), 256'(1'b1));
            chk("first_valid", 256'(valid_a), 256'(!degen && !first_culled));
         end
         if (!busy_a) break;
         busy_cyc++;
         if (valid_a && stall_left > 0) begin
            busy_i = 1'b1;
            stall_left--;
         end else begin
            busy_i = ($urandom_range(0, 99) < busy_pct);
         end
         #1;
         if (held_v) begin
            chk("held_valid", 256'(valid_a), 256'(1'b1));
            chk("held_tile", vec_a(), held);
         end
         held_v = 1'b0;
         if (valid_a && busy_i) begin
            held_v = 1'b1;
            held   = vec_a();
            stalls++;
         end else if (valid_a) begin
            ntr++;
            if (exp_q.size() > 0) chk("tile", vec_a(), exp_vec(exp_q.pop_front()));
            else chk("tile_count", 256'(ntr), 256'(n_unc));
         end
         @(negedge clk);
         cyc++;
      end
      busy_i = 1'b0;
      chk("walk_done", 256'(busy_a), 256'(1'b0));
      chk("n_transfers", 256'(ntr), 256'(n_unc));
      chk("busy_cycles", 256'(busy_cyc), 256'(degen ? 1 : n_cull_exp + n_unc + stalls));
      exp_emit  += n_unc;
      exp_cull  += n_cull_exp;
      exp_emit2 += n2;
      chk("emitted", 256'(emit_a), 256'(exp_emit));
      chk("culled", 256'(cull_a), 256'(exp_cull));
      for (int i = 0; i < 3000 && busy_b; i++) @(negedge clk);
      chk("b_done", 256'(busy_b), 256'(1'b0));
      chk("b_emitted", 256'(emit_b), 256'(exp_emit2));
      chk("b_culled", 256'(cull_b), 256'(16'd0));
   endtask

   initial begin
      #1 rst = 1'b1;
      #2;
      chk("rst_busy", 256'({busy_a, busy_b}), 256'(2'b00));
      chk("rst_valid", 256'({valid_a, valid_b}), 256'(2'b00));
      chk("rst_counters", 256'({emit_a, cull_a, emit_b, cull_b}), 256'(64'd0));
      chk("rst_regs", 256'({xmn_a, ymn_a, w0_a, w1_a, w2_a}), 256'(99'd0));
      repeat (2) @(negedge clk);
      rst = 1'b0;

      set_tri(0, 0, 15, 15, 100, 200, 300, 2, 3);
      run_tri(0, 30);
      set_tri(3, 5, 40, 20, 1000, 2000, 3000, 5, 3);
      run_tri(0, 30);
      set_tri(0, 0, 15, 15, -100, 100, 100, 0, 0);
      run_tri(0, 0);
      set_tri(0, 0, 31, 15, 500, 500, 500, 1, 1);
      run_tri(10, 0);
      set_tri(10, 0, 9, 5, 500, 500, 500, 1, 1);
      run_tri(0, 0);
      set_tri(4090, 4080, 4095, 4095, 50, 50, 50, -1, -1);
      run_tri(0, 20);
      set_tri(0, 0, 63, 20, -50, 800, 800, 10, 0);
      run_tri(0, 20);

      // Asynchronous reset in the middle of a 4-tile walk
      set_tri(0, 0, 31, 31, 500, 500, 500, 1, 1);
      @(negedge clk);
      drive_tri();
      valid_i = 1'b1;
      @(negedge clk);
      valid_i = 1'b0;
      busy_i  = 1'b1;
      repeat (2) @(negedge clk);
      #1 chk("pre_reset_valid", 256'(valid_a), 256'(1'b1));
      #1 rst = 1'b1;
      #1;
      chk("async_valid", 256'({valid_a, valid_b}), 256'(2'b00));
      chk("async_busy", 256'({busy_a, busy_b}), 256'(2'b00));
      chk("async_counters", 256'({emit_a, cull_a, emit_b, cull_b}), 256'(64'd0));
      @(negedge clk);
      rst    = 1'b0;
      busy_i = 1'b0;
      exp_emit = 0; exp_cull = 0; exp_emit2 = 0;
      repeat (3) begin
         @(negedge clk);
         #1 chk("post_reset_quiet", 256'({valid_a, busy_a}), 256'(2'b00));
      end
      set_tri(20, 40, 50, 60, 700, 700, 700, 2, 1);
      run_tri(0, 30);

      for (int n = 0; n < 40; n++) begin
         tx0 = $urandom_range(1, 200);
         ty0 = $urandom_range(1, 200);
         tx1 = ($urandom_range(0, 9) == 0) ? tx0 - 1 : tx0 + $urandom_range(0, 47);
         ty1 = ($urandom_range(0, 9) == 0) ? ty0 - 1 : ty0 + $urandom_range(0, 47);
         for (int k = 0; k < 3; k++) begin
            tw[k]  = int'($urandom_range(0, 12000)) - 6000;
            tdc[k] = int'($urandom_range(0, 600)) - 300;
            tdr[k] = int'($urandom_range(0, 600)) - 300;
         end
         tarea = int'($urandom_range(0, 24'hFFFFFF));
         run_tri(0, 30);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
